// File: rtl/serial_sub_8.sv
// -----------------------------------------------------------------------------
// serial_sub_8
//   Bit-serial unsigned subtractor: computes a - b (mod 2^WIDTH) LSB-first, one
//   bit per clock, through a single full-subtractor cell and a borrow flop.
//   A start/done handshake frames each operation and the difference bits are
//   also streamed out as they are produced.
//
// Ports
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   begin a subtraction (sampled in IDLE only, never queued)
//   a        in   minuend, captured on the accepting edge
//   b        in   subtrahend, captured on the accepting edge
//   busy     out  high while bits are being processed (RUN)
//   done     out  one-cycle pulse while the fresh result is first visible
//   diff     out  registered a - b mod 2^WIDTH, held until the next done
//   borrow   out  registered final borrow (a < b unsigned)
//   sbit     out  most recently produced difference bit
//   svalid   out  sbit was produced by the preceding processing edge
// -----------------------------------------------------------------------------
module serial_sub_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             sbit,
    output logic             svalid
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             x;
    logic             y;
    logic             d;
    logic             br_next;

    // Full-subtractor cell on the current LSBs of the operand shifters.
    assign x       = sa[0];
    assign y       = sb[0];
    assign d       = x ^ y ^ br;
    assign br_next = (~x & y) | (~(x ^ y) & br);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST_BIT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            sbit   <= 1'b0;
            svalid <= 1'b0;
        end else begin
            // svalid only stays high across consecutive processing edges.
            svalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa     <= {1'b0, sa[WIDTH-1:1]};
                    sb     <= {1'b0, sb[WIDTH-1:1]};
                    sd     <= {d, sd[WIDTH-1:1]};
                    br     <= br_next;
                    sbit   <= d;
                    svalid <= 1'b1;
                    cnt    <= cnt + 1'b1;
                    // Final bit: publish the completed word so it is already
                    // visible in the DONE cycle; a partial word never reaches diff.
                    if (cnt == LAST_BIT) begin
                        diff   <= {d, sd[WIDTH-1:1]};
                        borrow <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub_8.sv
// -----------------------------------------------------------------------------
// tb_serial_sub_8
//   Directed bench for serial_sub_8 (WIDTH = 8). Inputs change and outputs are
//   sampled on the falling clock edge, half a period away from the active edge.
// -----------------------------------------------------------------------------
module tb_serial_sub_8;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
    logic       sbit;
    logic       svalid;

    int checks = 0;
    int errors = 0;

    serial_sub_8 #(.WIDTH(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .borrow  (borrow),
        .sbit    (sbit),
        .svalid  (svalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One full operation with start pulsed for a single cycle; checks the
    // handshake, the serial stream bit by bit and the registered result.
    task automatic run_sub(input logic [7:0] av, input logic [7:0] bv,
                           input logic [7:0] exp_d, input logic exp_b,
                           input string name);
        logic [7:0] bits;
        bits = exp_d;
        @(negedge clock);
        a = av; b = bv; start = 1'b1;
        @(negedge clock);                 // acceptance edge E0 has passed
        start = 1'b0;
        checks++;
        if ({busy, done, svalid} !== 3'b100) begin
            errors++;
            $display("FAIL %s accept: busy/done/svalid=%b expected 100", name, {busy, done, svalid});
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);             // after edge E0+k+1
            checks++;
            if (svalid !== 1'b1 || sbit !== bits[k]) begin
                errors++;
                $display("FAIL %s sbit[%0d]: svalid=%b sbit=%b expected svalid=1 sbit=%b",
                         name, k, svalid, sbit, bits[k]);
            end
            checks++;
            if (done !== (k == 7) || busy !== (k != 7)) begin
                errors++;
                $display("FAIL %s handshake[%0d]: done=%b busy=%b expected done=%b busy=%b",
                         name, k, done, busy, (k == 7), (k != 7));
            end
        end
        checks++;
        if (diff !== exp_d || borrow !== exp_b) begin
            errors++;
            $display("FAIL %s result: diff=%h borrow=%b expected diff=%h borrow=%b",
                     name, diff, borrow, exp_d, exp_b);
        end
        @(negedge clock);
        checks++;
        if ({busy, done, svalid} !== 3'b000) begin
            errors++;
            $display("FAIL %s idle_after: busy/done/svalid=%b expected 000", name, {busy, done, svalid});
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; a = 8'h5A; b = 8'h23;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            start = ~start;
        end
        #1;
        checks++;
        if ({busy, done, diff, borrow, sbit, svalid} !== 13'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b diff=%h borrow=%b sbit=%b svalid=%b expected all 0",
                     busy, done, diff, borrow, sbit, svalid);
        end
        @(negedge clock);
        start = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if ({busy, done, svalid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: busy/done/svalid=%b expected 000", {busy, done, svalid});
        end
    endtask

    task automatic test_basic();
        run_sub(8'h5A, 8'h23, 8'h37, 1'b0, "basic");
    endtask

    task automatic test_borrow();
        run_sub(8'h23, 8'h5A, 8'hC9, 1'b1, "borrow");
    endtask

    task automatic test_extremes();
        run_sub(8'h00, 8'h01, 8'hFF, 1'b1, "zero_minus_one");
        run_sub(8'h80, 8'h80, 8'h00, 1'b0, "equal");
    endtask

    // start held high throughout; operands change during the first RUN.
    task automatic test_back_to_back();
        int first_done  = -1;
        int second_done = -1;
        @(negedge clock);
        a = 8'h5A; b = 8'h23; start = 1'b1;
        @(negedge clock);                 // i = 0, E0 has passed
        a = 8'hFF; b = 8'h0F;
        for (int i = 1; i <= 30 && second_done < 0; i++) begin
            @(negedge clock);
            if (done) begin
                if (first_done < 0) begin
                    first_done = i;
                    checks++;
                    if (diff !== 8'h37 || borrow !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b first_result: diff=%h borrow=%b expected diff=37 borrow=0",
                                 diff, borrow);
                    end
                end else begin
                    second_done = i;
                    start = 1'b0;
                end
            end else if (first_done >= 0) begin
                checks++;
                if (diff !== 8'h37) begin
                    errors++;
                    $display("FAIL b2b diff_hold[%0d]: diff=%h expected 37", i, diff);
                end
                if (i == first_done + 1) begin
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b idle_gap: busy=%b expected 0", busy);
                    end
                end
            end
        end
        start = 1'b0;
        checks++;
        if (first_done != 8) begin
            errors++;
            $display("FAIL b2b first_latency: done at %0d expected 8", first_done);
        end
        checks++;
        if (second_done - first_done != 10 || first_done < 0) begin
            errors++;
            $display("FAIL b2b spacing: %0d expected 10", second_done - first_done);
        end
        checks++;
        if (diff !== 8'hF0 || borrow !== 1'b0) begin
            errors++;
            $display("FAIL b2b second_result: diff=%h borrow=%b expected diff=F0 borrow=0", diff, borrow);
        end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL b2b end_idle: busy/done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_mid_reset();
        int seen_done = 0;
        @(negedge clock);
        a = 8'h5A; b = 8'h23; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);      // four RUN edges processed
        checks++;
        if (busy !== 1'b1 || diff !== 8'hF0) begin
            errors++;
            $display("FAIL midrst pre: busy=%b diff=%h expected busy=1 diff=F0", busy, diff);
        end
        #2;
        reset_n = 1'b0;
        #1;                               // well before the next rising edge
        checks++;
        if ({busy, done, diff, borrow, sbit, svalid} !== 13'd0) begin
            errors++;
            $display("FAIL midrst async_clear: busy=%b done=%b diff=%h borrow=%b sbit=%b svalid=%b expected all 0",
                     busy, done, diff, borrow, sbit, svalid);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done != 0 || diff !== 8'h00) begin
            errors++;
            $display("FAIL midrst no_done: activity cycles=%0d diff=%h expected 0 and 00", seen_done, diff);
        end
        run_sub(8'h10, 8'h01, 8'h0F, 1'b0, "after_reset");
    endtask

    initial begin
        a = '0; b = '0; start = 1'b0; reset_n = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_extremes();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
